// File: rtl/ftdi_tx_writer.sv
`default_nettype none
// ============================================================================
// Module   : ftdi_tx_writer
// Purpose  : Pops 16-bit words from the SDRAM read-back FIFO and writes them
//            as two bytes into the FT2232H synchronous 245 FIFO port.
//            Build option FTDI_TX_SWAP_EN sends the high byte first.
// Revision : 1.0 - initial release
// ============================================================================
module ftdi_tx_writer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             enable,
    input  logic [15:0]      fifo_q,
    input  logic             fifo_empty,
    output logic             fifo_rdreq,
    input  logic             ftxe,
    output logic             fwr_n,
    output logic [7:0]       fu_d_out,
    output logic             fu_d_oe,
    output logic             busy,
    output logic [CNT_W-1:0] bytes_sent
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        LATCH  = 3'd2,
        SEND_A = 3'd3,
        SEND_B = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_word;
    logic [15:0]      w_word_nxt;
    logic             r_rdreq;
    logic             w_rdreq_nxt;
    logic             r_fwr_n;
    logic             w_fwr_n_nxt;
    logic [7:0]       r_data;
    logic [7:0]       w_data_nxt;
    logic             r_oe;
    logic             w_oe_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_accept;

`ifdef FTDI_TX_SWAP_EN
    function automatic logic [7:0] first_byte(input logic [15:0] w);
        return w[15:8];
    endfunction
    function automatic logic [7:0] second_byte(input logic [15:0] w);
        return w[7:0];
    endfunction
`else
    function automatic logic [7:0] first_byte(input logic [15:0] w);
        return w[7:0];
    endfunction
    function automatic logic [7:0] second_byte(input logic [15:0] w);
        return w[15:8];
    endfunction
`endif

    // A byte moves only when our registered strobe and the FTDI's TXE# are both low.
    assign w_accept = ~r_fwr_n & ~ftxe;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_word  <= 16'h0000;
            r_rdreq <= 1'b0;
            r_fwr_n <= 1'b1;
            r_data  <= 8'h00;
            r_oe    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_word  <= w_word_nxt;
            r_rdreq <= w_rdreq_nxt;
            r_fwr_n <= w_fwr_n_nxt;
            r_data  <= w_data_nxt;
            r_oe    <= w_oe_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_rdreq_nxt = 1'b0;
        w_fwr_n_nxt = r_fwr_n;
        w_data_nxt  = r_data;
        w_oe_nxt    = r_oe;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            IDLE: begin
                w_fwr_n_nxt = 1'b1;
                w_oe_nxt    = 1'b0;
                if (enable && !fifo_empty) begin
                    w_state_nxt = REQ;
                    w_rdreq_nxt = 1'b1;
                end
            end
            REQ: begin
                w_state_nxt = LATCH;
            end
            LATCH: begin
                // Read data from the normal-mode FIFO is valid in this cycle only.
                w_word_nxt  = fifo_q;
                w_data_nxt  = first_byte(fifo_q);
                w_fwr_n_nxt = 1'b0;
                w_oe_nxt    = 1'b1;
                w_state_nxt = SEND_A;
            end
            SEND_A: begin
                if (w_accept) begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_data_nxt  = second_byte(r_word);
                    w_state_nxt = SEND_B;
                end
            end
            SEND_B: begin
                if (w_accept) begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_fwr_n_nxt = 1'b1;
                    w_oe_nxt    = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_word_nxt  = 16'h0000;
                w_fwr_n_nxt = 1'b1;
                w_data_nxt  = 8'h00;
                w_oe_nxt    = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign fifo_rdreq = r_rdreq;
    assign fwr_n      = r_fwr_n;
    assign fu_d_out   = r_data;
    assign fu_d_oe    = r_oe;
    assign busy       = (r_state != IDLE);
    assign bytes_sent = r_cnt;

endmodule
`default_nettype wire
